alu32_divider: RTL and testbench

Iterative 32-bit unsigned restoring divider. It is the initiator side of the alu32 interface: it sequences A/B/control into one alu32 instance (ALU_SUB each step) and consumes out/negative. It gives datapath users a multi-cycle divide with a start/busy/done handshake.

---
 rtl/alu32_divider_pkg.sv | 33 +++
 rtl/alu32_divider_alu32.sv | 45 ++++
 rtl/alu32_divider.sv | 167 ++++++++++++++++
 tb/tb_alu32_divider.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/alu32_divider_pkg.sv
// Shared definitions for the alu32 iterative divider.
//   - alu32 control codes (3 bits)
//   - divider FSM state encoding (2 bits)
//   - ALU request payload carried from the divider to its alu32 instance
package alu32_divider_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned ALU_CTRL_W = 3;

  typedef enum logic [ALU_CTRL_W-1:0] {
    ALU_AND = 3'd0,
    ALU_OR  = 3'd1,
    ALU_ADD = 3'd2,
    ALU_XOR = 3'd3,
    ALU_NOR = 3'd4,
    ALU_SUB = 3'd6
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    DZERO = 2'd2,
    FIN   = 2'd3
  } div_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    alu_ctrl_e         control;
  } alu_req_t;

endpackage

// File: rtl/alu32_divider_alu32.sv
// alu32: 32-bit combinational ALU.
// Ports:
//   a, b      in  32  operands
//   control   in  3   operation select (alu_ctrl_e)
//   out       out 32  result
//   zero      out 1   out == 0
//   overflow  out 1   signed overflow for ADD/SUB, 0 otherwise
//   negative  out 1   out[31]
module alu32
  import alu32_divider_pkg::*;
(
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  input  logic [ALU_CTRL_W-1:0] control,
  output logic [DATA_W-1:0]     out,
  output logic                  zero,
  output logic                  overflow,
  output logic                  negative
);

  // Operation select plus signed-overflow detection
  always_comb begin
    out      = '0;
    overflow = 1'b0;
    case (control)
      ALU_AND: out = a & b;
      ALU_OR:  out = a | b;
      ALU_NOR: out = ~(a | b);
      ALU_XOR: out = a ^ b;
      ALU_ADD: begin
        out      = a + b;
        overflow = (a[DATA_W-1] == b[DATA_W-1]) && (out[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_SUB: begin
        out      = a - b;
        overflow = (a[DATA_W-1] != b[DATA_W-1]) && (out[DATA_W-1] != a[DATA_W-1]);
      end
      default: out = '0;
    endcase
  end

  assign zero     = (out == '0);
  assign negative = out[DATA_W-1];

endmodule

// File: rtl/alu32_divider.sv
// alu32_divider: iterative 32-bit unsigned restoring divider driving one alu32.
// Ports:
//   clk, reset        clock (rising edge), synchronous active-high reset
//   start             request, sampled only in IDLE
//   dividend, divisor operands captured on accepted start
//   busy              high in ITER/FIN
//   done              one-cycle pulse when results are loaded
//   div_by_zero       result flag, held until next accepted start
//   quotient          result, held until next accepted start
//   remainder         result, held until next accepted start
// WIDTH must stay 32; the alu32 datapath is fixed at that width.
module alu32_divider
  import alu32_divider_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  alu_req_t         alu_req;
  logic [WIDTH-1:0] alu_out;
  logic             alu_zero;
  logic             alu_overflow;
  logic             alu_negative;
  logic [WIDTH-1:0] shifted;
  logic             msb;
  logic             borrow;
  logic             take;
  logic             unused_alu_flags;

  alu32 u_alu (
    .a        (alu_req.a),
    .b        (alu_req.b),
    .control  (alu_req.control),
    .out      (alu_out),
    .zero     (alu_zero),
    .overflow (alu_overflow),
    .negative (alu_negative)
  );

  // Zero and overflow flags have no role in the trial subtraction
  assign unused_alu_flags = alu_zero | alu_overflow;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (divisor == '0) ? DZERO : ITER;
      ITER:    if (count_q == CNT_W'(WIDTH - 1)) state_d = FIN;
      DZERO:   state_d = IDLE;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    rem_d       = rem_q;
    q_d         = q_q;
    dvsr_d      = dvsr_q;
    count_d     = count_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dz_d        = dz_q;
    done_d      = 1'b0;
    alu_req     = '{a: '0, b: '0, control: ALU_ADD};

    // Trial subtraction of the divisor from the shifted partial remainder;
    // a set msb means the true 33-bit value already exceeds the divisor.
    shifted = {rem_q[WIDTH-2:0], q_q[WIDTH-1]};
    msb     = rem_q[WIDTH-1];
    borrow  = (~shifted[WIDTH-1] & dvsr_q[WIDTH-1]) |
              (~(shifted[WIDTH-1] ^ dvsr_q[WIDTH-1]) & alu_negative);
    take    = msb | ~borrow;

    case (state_q)
      IDLE: begin
        if (start) begin
          dvsr_d  = divisor;
          q_d     = dividend;
          rem_d   = '0;
          count_d = '0;
        end
      end
      ITER: begin
        alu_req = '{a: shifted, b: dvsr_q, control: ALU_SUB};
        rem_d   = take ? alu_out : shifted;
        q_d     = {q_q[WIDTH-2:0], take};
        count_d = count_q + CNT_W'(1);
      end
      DZERO: begin
        // q_q still holds the captured dividend here
        quotient_d  = '1;
        remainder_d = q_q;
        dz_d        = 1'b1;
        done_d      = 1'b1;
      end
      FIN: begin
        quotient_d  = q_q;
        remainder_d = rem_q;
        dz_d        = 1'b0;
        done_d      = 1'b1;
      end
      default: ;
    endcase

    busy_d = (state_d == ITER) || (state_d == FIN);
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q       <= '0;
      q_q         <= '0;
      dvsr_q      <= '0;
      count_q     <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dz_q        <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      rem_q       <= rem_d;
      q_q         <= q_d;
      dvsr_q      <= dvsr_d;
      count_q     <= count_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dz_q        <= dz_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dz_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;

endmodule

// File: tb/tb_alu32_divider.sv
// Directed testbench for alu32_divider: hand-computed quotients/remainders,
// latency, busy window, done pulse, ignored start, back-to-back and reset abort.
module tb_alu32_divider;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int n_vec;
  int n_err;

  alu32_divider #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .quotient    (quotient),
    .remainder   (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full operation from a single start pulse; checks latency, busy window,
  // held outputs during iteration, results and the one-cycle done pulse.
  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic edz);
    int          lat;
    int          nbusy;
    int          unstable;
    int          exp_lat;
    int          exp_busy;
    logic [31:0] pq;
    exp_lat  = edz ? 1 : 33;
    exp_busy = edz ? 0 : 33;
    pq       = quotient;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    lat      = 0;
    nbusy    = 0;
    unstable = 0;
    while (!done && lat < 60) begin
      if (busy) nbusy++;
      if (quotient !== pq) unstable++;
      tick();
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " busy_cycles"}, 32'(nbusy), 32'(exp_busy));
    check({tag, " held_quotient"}, 32'(unstable), 32'd0);
    check({tag, " quotient"}, quotient, eq);
    check({tag, " remainder"}, remainder, er);
    check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(edz));
    check({tag, " busy_at_done"}, 32'(busy), 32'd0);
    tick();
    check({tag, " done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int          ndone;
    int          cyc;
    logic [31:0] cq;
    logic [31:0] cr;

    n_vec    = 0;
    n_err    = 0;
    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    tick();
    tick();
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst dz", 32'(div_by_zero), 32'd0);
    check("rst quotient", quotient, 32'd0);
    check("rst remainder", remainder, 32'd0);
    reset = 1'b0;
    tick();

    do_div("100/7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    do_div("ffffffff/1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
    do_div("80000000/80000001", 32'h8000_0000, 32'h8000_0001, 32'd0, 32'h8000_0000, 1'b0);
    do_div("7/100", 32'd7, 32'd100, 32'd0, 32'd7, 1'b0);
    do_div("ffffffff/ffffffff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
    do_div("5/0", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
    do_div("9/3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

    // Second start in the middle of an operation must be ignored
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    dividend = 32'd50;
    divisor  = 32'd5;
    start    = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    cq    = '0;
    cr    = '0;
    for (int i = 0; i < 60; i++) begin
      if (done) begin
        ndone++;
        cq = quotient;
        cr = remainder;
      end
      tick();
    end
    check("ignored_start done_count", 32'(ndone), 32'd1);
    check("ignored_start quotient", cq, 32'd14);
    check("ignored_start remainder", cr, 32'd2);

    // start held high: second operation accepted right after done,
    // with operands not re-sampled afterwards
    dividend = 32'd20;
    divisor  = 32'd6;
    start    = 1'b1;
    tick();
    cyc = 0;
    while (!done && cyc < 60) begin
      tick();
      cyc++;
    end
    check("b2b first latency", 32'(cyc), 32'd33);
    check("b2b first quotient", quotient, 32'd3);
    tick();
    start    = 1'b0;
    dividend = 32'd0;
    divisor  = 32'd0;
    check("b2b second busy", 32'(busy), 32'd1);
    cyc = 0;
    while (!done && cyc < 60) begin
      tick();
      cyc++;
    end
    check("b2b second latency", 32'(cyc), 32'd33);
    check("b2b second quotient", quotient, 32'd3);
    check("b2b second remainder", remainder, 32'd2);
    check("b2b second dz", 32'(div_by_zero), 32'd0);
    tick();

    // Reset in the middle of an operation
    dividend = 32'd1000;
    divisor  = 32'd3;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 11; i++) tick();
    check("pre_reset busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_reset busy", 32'(busy), 32'd0);
    check("mid_reset done", 32'(done), 32'd0);
    check("mid_reset quotient", quotient, 32'd0);
    check("mid_reset remainder", remainder, 32'd0);
    check("mid_reset dz", 32'(div_by_zero), 32'd0);
    ndone = 0;
    for (int i = 0; i < 50; i++) begin
      if (done || busy) ndone++;
      tick();
    end
    check("post_reset quiet", 32'(ndone), 32'd0);
    do_div("1000/3", 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
